// File: rtl/cal_burst_divider.sv
// Programmable even-ratio calibration clock divider with whole-pulse enable gating
// and an optional burst mode that emits N pulses and then flags completion.
module cal_burst_divider #(
  parameter int DIV_W   = 6,
  parameter int BURST_W = 8
) (
  input  logic               cal_clkin,
  input  logic               cal_reset,
  input  logic               cal_load,
  input  logic [DIV_W-1:0]   cal_divcount,
  input  logic               cal_mode,
  input  logic [BURST_W-1:0] cal_burst,
  input  logic               cal_en,
  output logic               cal_out,
  output logic               cal_busy,
  output logic               cal_done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_W-1:0]     r_div;
  logic                 r_mode;
  logic [BURST_W-1:0]   r_burst;
  logic [DIV_W-1:0]     r_cnt;
  logic                 r_ph;
  logic [BURST_W-1:0]   r_pcnt;
  logic                 r_out;
  logic                 r_done;
  logic                 w_out_nxt;
  logic                 w_done_nxt;
  logic                 w_tick;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_end;
  logic                 w_load_empty;

  assign w_tick       = (r_state == S_RUN) && (r_cnt == r_div);
  assign w_rise       = w_tick && !r_ph;
  assign w_fall       = w_tick && r_ph;
  assign w_end        = w_fall && r_mode && (r_pcnt == r_burst);
  // A burst of zero pulses completes on the spot without ever running.
  assign w_load_empty = cal_load && cal_mode && (cal_burst == '0);

  always_ff @(posedge cal_clkin) begin
    if (!cal_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cal_load) begin
      w_state_nxt = w_load_empty ? S_IDLE : S_RUN;
    end else if (w_end) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Load takes priority over burst termination, so a coincident load suppresses done.
  always_comb begin
    w_out_nxt  = r_out;
    w_done_nxt = 1'b0;
    if (cal_load) begin
      w_out_nxt  = 1'b0;
      w_done_nxt = w_load_empty;
    end else if (r_state != S_RUN) begin
      w_out_nxt  = 1'b0;
    end else if (w_rise) begin
      w_out_nxt  = cal_en;
    end else if (w_fall) begin
      w_out_nxt  = 1'b0;
      w_done_nxt = w_end;
    end
  end

  always_ff @(posedge cal_clkin) begin
    if (!cal_reset) begin
      r_div   <= '0;
      r_mode  <= 1'b0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_ph    <= 1'b0;
      r_pcnt  <= '0;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_out  <= w_out_nxt;
      r_done <= w_done_nxt;
      if (cal_load) begin
        r_div   <= cal_divcount;
        r_mode  <= cal_mode;
        r_burst <= cal_burst;
        r_cnt   <= '0;
        r_ph    <= 1'b0;
        r_pcnt  <= '0;
      end else if (r_state == S_RUN) begin
        if (w_end) begin
          r_cnt <= '0;
          r_ph  <= 1'b0;
        end else if (w_tick) begin
          r_cnt <= '0;
          r_ph  <= ~r_ph;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
        // Only pulses actually emitted count toward the burst length.
        if (w_rise && cal_en) begin
          r_pcnt <= r_pcnt + BURST_W'(1);
        end
      end
    end
  end

  assign cal_out  = r_out;
  assign cal_busy = (r_state == S_RUN);
  assign cal_done = r_done;

endmodule

// File: tb/tb_cal_burst_divider.sv
// Scoreboard bench for cal_burst_divider: each driven cycle queues the expected
// {out,busy,done} after the next edge; a monitor pops and compares after every edge.
module tb_cal_burst_divider;

  logic       clk;
  logic       rst;
  logic       load;
  logic [5:0] divCount;
  logic       mode;
  logic [7:0] burst;
  logic       en;
  logic       calOut;
  logic       calBusy;
  logic       calDone;

  typedef struct {
    logic  out;
    logic  busy;
    logic  done;
    string tag;
  } expect_t;

  expect_t expQ[$];
  int      checkCount = 0;
  int      errorCount = 0;

  cal_burst_divider #(.DIV_W(6), .BURST_W(8)) dut (
    .cal_clkin    (clk),
    .cal_reset    (rst),
    .cal_load     (load),
    .cal_divcount (divCount),
    .cal_mode     (mode),
    .cal_burst    (burst),
    .cal_en       (en),
    .cal_out      (calOut),
    .cal_busy     (calBusy),
    .cal_done     (calDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input expect_t e);
    checkCount++;
    if (calOut !== e.out || calBusy !== e.busy || calDone !== e.done) begin
      errorCount++;
      $display("[TB] FAIL %s: out/busy/done got %b%b%b expected %b%b%b",
               e.tag, calOut, calBusy, calDone, e.out, e.busy, e.done);
    end
  endtask

  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic ld, input logic [5:0] d,
                               input logic md, input logic [7:0] b, input logic enable,
                               input logic eo, input logic eb, input logic ed,
                               input string tag);
    expect_t e;
    @(negedge clk);
    rst      = r;
    load     = ld;
    divCount = d;
    mode     = md;
    burst    = b;
    en       = enable;
    e.out    = eo;
    e.busy   = eb;
    e.done   = ed;
    e.tag    = tag;
    expQ.push_back(e);
  endtask

  initial begin
    logic eo;
    int   waitCycles;
    rst = 1'b0; load = 1'b0; divCount = '0; mode = 1'b0; burst = '0; en = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, "reset1");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, "idle");

    // div=0 continuous: output toggles every clock, high after odd edges
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 1, 0, "cont_load");
    for (int t = 1; t <= 8; t++)
      applyStimulus(1, 0, 0, 0, 0, 1, logic'(t % 2), 1, 0, $sformatf("cont_t%0d", t));

    // div=3 burst of 4 with enable held high: done after edge k+32
    applyStimulus(1, 1, 3, 1, 4, 1, 0, 1, 0, "burst_load");
    for (int t = 1; t <= 31; t++)
      applyStimulus(1, 0, 7, 0, 9, 1, logic'((t / 4) % 2), 1, 0, $sformatf("burst_t%0d", t));
    applyStimulus(1, 0, 7, 0, 9, 1, 0, 0, 1, "burst_end");
    applyStimulus(1, 0, 7, 0, 9, 1, 0, 0, 0, "burst_done_clr");

    // Enable drops mid pulse 2 (t=14) and stays low through pulse 3's rise (t=20)
    applyStimulus(1, 1, 3, 1, 4, 1, 0, 1, 0, "gate_load");
    for (int t = 1; t <= 39; t++) begin
      eo = logic'((t / 4) % 2 == 1 && (t / 8) != 2);
      applyStimulus(1, 0, 3, 1, 4, !(t >= 14 && t <= 23), eo, 1, 0, $sformatf("gate_t%0d", t));
    end
    applyStimulus(1, 0, 3, 1, 4, 1, 0, 0, 1, "gate_end");
    applyStimulus(1, 0, 3, 1, 4, 1, 0, 0, 0, "gate_done_clr");

    // Zero-length burst completes immediately without running
    applyStimulus(1, 1, 2, 1, 0, 1, 0, 0, 1, "zero_load");
    for (int t = 1; t <= 3; t++)
      applyStimulus(1, 0, 2, 1, 0, 1, 0, 0, 0, $sformatf("zero_t%0d", t));

    // div=5 continuous, reloaded mid-pulse with div=1
    applyStimulus(1, 1, 5, 0, 0, 1, 0, 1, 0, "rl_load5");
    for (int t = 1; t <= 6; t++)
      applyStimulus(1, 0, 5, 0, 0, 1, logic'((t / 6) % 2), 1, 0, $sformatf("rl5_t%0d", t));
    applyStimulus(1, 1, 1, 0, 0, 1, 0, 1, 0, "rl_load1");
    for (int t = 1; t <= 8; t++)
      applyStimulus(1, 0, 1, 0, 0, 1, logic'((t / 2) % 2), 1, 0, $sformatf("rl1_t%0d", t));

    // Burst of 2 at div=1 ends at t=8; a load on that edge wins, no done
    applyStimulus(1, 1, 1, 1, 2, 1, 0, 1, 0, "coin_load");
    for (int t = 1; t <= 7; t++)
      applyStimulus(1, 0, 1, 1, 2, 1, logic'((t / 2) % 2), 1, 0, $sformatf("coin_t%0d", t));
    applyStimulus(1, 1, 1, 1, 1, 1, 0, 1, 0, "coin_reload");
    for (int t = 1; t <= 3; t++)
      applyStimulus(1, 0, 1, 1, 1, 1, logic'((t / 2) % 2), 1, 0, $sformatf("coin2_t%0d", t));
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 0, 1, "coin2_end");
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 0, 0, "coin2_clr");

    // Reset coincident with load during RUN: everything clears and stays idle
    applyStimulus(1, 1, 2, 0, 0, 1, 0, 1, 0, "rst_load");
    for (int t = 1; t <= 4; t++)
      applyStimulus(1, 0, 2, 0, 0, 1, logic'((t / 3) % 2), 1, 0, $sformatf("rst_t%0d", t));
    applyStimulus(0, 1, 2, 0, 0, 1, 0, 0, 0, "rst_with_load");
    for (int t = 1; t <= 4; t++)
      applyStimulus(1, 0, 2, 0, 0, 1, 0, 0, 0, $sformatf("rst_idle_t%0d", t));

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drain: pending %0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/cal_burst_divider.md
# cal_burst_divider

Parametrised successor to the calibration clock divider. It divides `cal_clkin` by a programmable even ratio and produces a registered, glitch-free calibration output. The output is gated by an enable that only takes effect on whole pulses. An optional burst mode emits exactly N pulses and then stops with a completion flag. It sits between the sequencer's register bank and the calibration-pulse injection path of the NMR front end.

## Interface
Parameters:
- `DIV_W`, default 6: width of the divide-count field.
- `BURST_W`, default 8: width of the burst pulse-count field.

Ports (one clock domain; reset is synchronous and active-low):
- `cal_clkin`  in  1  sole clock; all logic on rising edge.
- `cal_reset`  in  1  synchronous active-low reset.
- `cal_load`  in  1  when high at an edge, latch configuration and (re)start.
- `cal_divcount`  in  DIV_W  half-period minus one; output period = 2*(cal_divcount+1) clocks.
- `cal_mode`  in  1  0 = continuous, 1 = burst.
- `cal_burst`  in  BURST_W  number of emitted pulses in burst mode.
- `cal_en`  in  1  output enable, applied per whole pulse.
- `cal_out`  out  1  registered divided/gated output.
- `cal_busy`  out  1  high while the divider is running.
- `cal_done`  out  1  one-cycle pulse when a burst completes.

## Operation
- **Shadow registers.** `div_q`, `mode_q` and `burst_q` are loaded only when `cal_load` is high. Input changes at other times have no effect.
- **States.** IDLE and RUN.
  - Reset leads to IDLE with: `cnt`=0, `ph`=0, pulse count `pcnt`=0, all shadows 0, `cal_out`=0, `cal_busy`=0, `cal_done`=0.
- **IDLE.**
  - `cal_load` with `mode`=0, or with `mode`=1 and `burst`≠0, goes to RUN.
  - `cal_load` with `mode`=1 and `burst`=0 stays in IDLE and pulses `cal_done` for one cycle.
- **Entering RUN.** `cnt`=0, `ph`=0, `pcnt`=0, `cal_out`=0.
- **RUN, each clock.**
  - If `cnt`==`div_q`: `cnt` goes to 0 and `ph` toggles.
  - Otherwise `cnt` increments. `cnt` is DIV_W wide and never wraps past `div_q`.
- **Enable gating.** On a `ph` 0→1 edge, `cal_out` takes the value of `cal_en` sampled at that edge. On a `ph` 1→0 edge, `cal_out` goes to 0. `cal_en` changes mid-pulse never truncate or create a pulse.
- **Burst counting.**
  - `pcnt` increments only on emitted pulses, i.e. rising edges where `cal_en`=1. Suppressed pulses are not counted, so a low `cal_en` pauses the burst.
  - On the falling edge of the pulse where `pcnt`==`burst_q`: go to IDLE, set `cal_done`=1 for one cycle, `cal_busy`=0, `ph`=0.
- **Continuous mode.** Runs until reset or a new load. `cal_done` is never asserted.
- **Load while in RUN.** Restarts immediately with the new configuration and zeroes `cal_out`. If the load coincides with the burst-terminating edge, the load wins and no `cal_done` is produced.
- **Reset while in RUN.** Reset overrides everything, including a coincident load.

## Timing
- Load sampled at edge k: after edge k, `cal_busy`=1 and `cal_out`=0.
- First `cal_out` rise (if `cal_en`=1) is after edge k+`div`+1.
- The pulse stays high for `div`+1 clocks and falls after edge k+2(`div`+1).
- Period is 2(`div`+1). For `div`=0 the output is `cal_clkin`/2, high after edges k+1, k+3, …
- Burst of N pulses with `cal_en` held high: last fall, `cal_done`=1 and `cal_busy`=0 all occur after edge k+2N(`div`+1).
- `cal_done` lasts exactly one cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then load `div`=0, `mode`=0, `cal_en`=1 → `cal_out` toggles every clock starting edge k+1; `cal_busy`=1; `cal_done` stays 0.
- Load `div`=3, `mode`=1, `burst`=4, `cal_en`=1 → 4 pulses, each 4 high / 4 low; `cal_done` pulse and `cal_busy` fall after edge k+32.
- Same burst, with `cal_en` dropped mid-high of pulse 2 and low for the whole of pulse 3 → pulse 2 is full width, pulse 3 is suppressed, and 4 pulses are still emitted; `cal_done` is at edge k+40.
- Load `mode`=1, `burst`=0 → no pulses, `cal_busy` stays 0, `cal_done`=1 for one cycle after edge k.
- While running at `div`=5, load `div`=1 mid-pulse → `cal_out` low after the load edge, then period 4 from restart; a load coincident with the burst-end edge produces no `cal_done`.
- Assert `cal_reset`=0 during RUN together with `cal_load` → all outputs 0 next cycle and the block stays in IDLE.
